// File: rtl/iter_fixed_point_square_if.sv
// Operand/result handshake bundle for iter_fixed_point_square.
// The master side drives operands and accepts results; the slave side is the squarer.
interface iter_fixed_point_square_if #(
  parameter int WI = 16,
  parameter int WO = 24
);
  logic          in_valid;
  logic          in_ready;
  logic [WI-1:0] in;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out;
  logic          overflow;

  modport master (
    output in_valid, output in, input in_ready,
    input out_valid, input out, input overflow, output out_ready
  );

  modport slave (
    input in_valid, input in, output in_ready,
    output out_valid, output out, output overflow, input out_ready
  );
endinterface

// File: rtl/iter_fixed_point_square.sv
// Multi-cycle signed fixed-point squarer: one shift-add step per operand bit,
// then a single formatting cycle that rounds/truncates and saturates into the output Q format.
module iter_fixed_point_square #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 16,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  iter_fixed_point_square_if.slave  bus
);
  localparam int N    = WII + WIF;
  localparam int PW   = 2 * N;
  localparam int WO   = WOI + WOF;
  localparam int SH_L = (WOF >= 2 * WIF) ? (WOF - 2 * WIF) : 0;
  localparam int SH_R = (WOF >= 2 * WIF) ? 0 : (2 * WIF - WOF);
  localparam int SW   = PW + SH_L + 1;
  localparam int CMPW = ((SW > WO) ? SW : WO) + 1;
  localparam int CNTW = ($clog2(N) > 0) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FMT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    mag_q, mag_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WO-1:0]   out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            vld_q, vld_d;

  logic [SW-1:0]   prod_ext;
  logic [SW-1:0]   scaled;
  logic            too_big;

  // One spare bit above the product keeps the rounding carry.
  assign prod_ext = SW'(acc_q) << SH_L;

  generate
    if (SH_R > 0) begin : g_rshift
      localparam logic [SW-1:0] HALF = (ROUND != 0) ? (SW'(1) << (SH_R - 1)) : '0;
      assign scaled = (prod_ext + HALF) >> SH_R;
    end else begin : g_lshift
      assign scaled = prod_ext;
    end
  endgenerate

  assign too_big = CMPW'(scaled) > CMPW'(MAX_POS);

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Unsigned negation maps the most negative operand to 2^(N-1) exactly.
          mag_d   = bus.in[N-1] ? (~bus.in + N'(1)) : bus.in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (mag_q[cnt_q]) begin
          acc_d = acc_q + (PW'(mag_q) << cnt_q);
        end
        if (cnt_q == CNTW'(N - 1)) begin
          state_d = S_FMT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_FMT: begin
        ovf_d   = too_big;
        out_d   = too_big ? MAX_POS : WO'(scaled);
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
endmodule
